tick_timebase: RTL and testbench

//   Parametrised timebase: exact divide-by-N tick pulse, runtime-loadable divisor, enable/clear, cascaded modulo

---
 rtl/tick_timebase.sv | 124 ++++++++++++
 tb/tb_tick_timebase.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tick_timebase.sv
// rtl/tick_timebase.sv - divide-by-N tick generator with loadable divisor, cascaded modulo counter and square wave
module tick_timebase #(
    parameter int DIV_WIDTH   = 27,
    parameter int DIV_DEFAULT = 100000000,
    parameter int CASCADE_MOD = 60,
    parameter int CNT_WIDTH   = 6
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 clear,
    input  logic                 div_load,
    input  logic [DIV_WIDTH-1:0] div_value,
    output logic                 tick,
    output logic [CNT_WIDTH-1:0] tick_count,
    output logic                 wrap_pulse,
    output logic                 square,
    output logic                 div_pending,
    output logic                 div_err
);

    localparam logic [DIV_WIDTH-1:0] LP_DIV_RST  = DIV_WIDTH'(DIV_DEFAULT);
    localparam logic [DIV_WIDTH-1:0] LP_DIV_MIN  = DIV_WIDTH'(2);
    localparam logic [DIV_WIDTH-1:0] LP_DIV_ONE  = DIV_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] LP_CNT_LAST = CNT_WIDTH'(CASCADE_MOD - 1);
    localparam logic [CNT_WIDTH-1:0] LP_CNT_ONE  = CNT_WIDTH'(1);

    logic [DIV_WIDTH-1:0] r_div_cur;
    logic [DIV_WIDTH-1:0] r_div_pend;
    logic                 r_pending;
    logic                 r_err;
    logic [DIV_WIDTH-1:0] r_pre_cnt;
    logic                 r_tick;
    logic [CNT_WIDTH-1:0] r_count;
    logic                 r_wrap;
    logic                 r_square;

    logic [DIV_WIDTH-1:0] w_div_last;
    logic                 w_terminal;
    logic                 w_div_ok;
    logic                 w_load_ok;
    logic                 w_load_bad;
    logic                 w_cnt_last;
    logic [DIV_WIDTH-1:0] w_div_next;

    assign w_div_last = r_div_cur - LP_DIV_ONE;
    assign w_terminal = enable && (r_pre_cnt == w_div_last);
    assign w_div_ok   = (div_value >= LP_DIV_MIN);
    assign w_load_ok  = div_load && w_div_ok;
    assign w_load_bad = div_load && !w_div_ok;
    assign w_cnt_last = (r_count == LP_CNT_LAST);

    // Divisor taking effect at a period boundary: a same-edge load beats an older pending one.
    always_comb begin
        w_div_next = r_div_cur;
        if (w_load_ok) begin
            w_div_next = div_value;
        end else if (r_pending) begin
            w_div_next = r_div_pend;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_div_cur  <= LP_DIV_RST;
            r_div_pend <= LP_DIV_RST;
            r_pending  <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_err <= w_load_bad;
            if (clear || w_terminal) begin
                r_div_cur <= w_div_next;
                r_pending <= 1'b0;
            end else if (w_load_ok) begin
                r_div_pend <= div_value;
                r_pending  <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pre_cnt <= '0;
            r_tick    <= 1'b0;
            r_count   <= '0;
            r_wrap    <= 1'b0;
            r_square  <= 1'b0;
        end else if (clear) begin
            r_pre_cnt <= '0;
            r_tick    <= 1'b0;
            r_count   <= '0;
            r_wrap    <= 1'b0;
            r_square  <= 1'b0;
        end else if (enable) begin
            if (w_terminal) begin
                r_pre_cnt <= '0;
                r_tick    <= 1'b1;
                r_square  <= ~r_square;
                if (w_cnt_last) begin
                    r_count <= '0;
                    r_wrap  <= 1'b1;
                end else begin
                    r_count <= r_count + LP_CNT_ONE;
                    r_wrap  <= 1'b0;
                end
            end else begin
                r_pre_cnt <= r_pre_cnt + LP_DIV_ONE;
                r_tick    <= 1'b0;
                r_wrap    <= 1'b0;
            end
        end else begin
            r_tick <= 1'b0;
            r_wrap <= 1'b0;
        end
    end

    assign tick        = r_tick;
    assign tick_count  = r_count;
    assign wrap_pulse  = r_wrap;
    assign square      = r_square;
    assign div_pending = r_pending;
    assign div_err     = r_err;

endmodule

// File: tb/tb_tick_timebase.sv
// tb/tb_tick_timebase.sv - self-checking bench for tick_timebase against a cycle-level reference model
module tb_tick_timebase;

    localparam int DW  = 8;
    localparam int DEF = 5;
    localparam int MOD = 3;
    localparam int CW  = 2;

    logic          clock;
    logic          reset;
    logic          enable;
    logic          clear;
    logic          div_load;
    logic [DW-1:0] div_value;
    logic          tick;
    logic [CW-1:0] tick_count;
    logic          wrap_pulse;
    logic          square;
    logic          div_pending;
    logic          div_err;

    int n_cmp = 0;
    int n_bad = 0;

    tick_timebase #(
        .DIV_WIDTH  (DW),
        .DIV_DEFAULT(DEF),
        .CASCADE_MOD(MOD),
        .CNT_WIDTH  (CW)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .clear      (clear),
        .div_load   (div_load),
        .div_value  (div_value),
        .tick       (tick),
        .tick_count (tick_count),
        .wrap_pulse (wrap_pulse),
        .square     (square),
        .div_pending(div_pending),
        .div_err    (div_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: integer bookkeeping of the period, divisor and count.
    int m_valid = 0;
    int m_pre, m_div, m_pend, m_pending, m_count, m_tick, m_wrap, m_square, m_err;

    initial begin
        forever begin
            @(posedge clock);
            if (reset) begin
                m_pre = 0; m_div = DEF; m_pend = DEF; m_pending = 0;
                m_count = 0; m_tick = 0; m_wrap = 0; m_square = 0; m_err = 0;
                m_valid = 1;
            end else if (m_valid == 1) begin
                int ok;
                int nd;
                ok    = (div_load && int'(div_value) >= 2) ? 1 : 0;
                m_err = (div_load && int'(div_value) < 2) ? 1 : 0;
                nd    = ok ? int'(div_value) : (m_pending ? m_pend : m_div);
                if (clear) begin
                    m_pre = 0; m_count = 0; m_tick = 0; m_wrap = 0; m_square = 0;
                    m_div = nd; m_pending = 0;
                end else if (enable && m_pre == m_div - 1) begin
                    m_pre    = 0;
                    m_tick   = 1;
                    m_count  = (m_count + 1) % MOD;
                    m_wrap   = (m_count == 0) ? 1 : 0;
                    m_square = 1 - m_square;
                    m_div    = nd; m_pending = 0;
                end else begin
                    if (enable) m_pre = m_pre + 1;
                    m_tick = 0; m_wrap = 0;
                    if (ok) begin m_pend = int'(div_value); m_pending = 1; end
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(negedge clock);
            if (m_valid == 1) begin
                chk("model_tick",    int'(tick),        m_tick);
                chk("model_count",   int'(tick_count),  m_count);
                chk("model_wrap",    int'(wrap_pulse),  m_wrap);
                chk("model_square",  int'(square),      m_square);
                chk("model_pending", int'(div_pending), m_pending);
                chk("model_err",     int'(div_err),     m_err);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        forever begin
            @(negedge clock);
            n++;
            if (tick) break;
            if (n >= 60) begin
                n_cmp++;
                n_bad++;
                $display("FAIL tick_timeout at %0t: no tick within %0d cycles", $time, n);
                break;
            end
        end
    endtask

    task automatic load(input int v);
        div_load  = 1'b1;
        div_value = DW'(v);
        cyc(1);
        div_load  = 1'b0;
    endtask

    int n;

    initial begin
        reset = 1'b1; enable = 1'b0; clear = 1'b0; div_load = 1'b0; div_value = '0;
        cyc(3);
        chk("rst_tick", int'(tick), 0);
        chk("rst_count", int'(tick_count), 0);
        chk("rst_square", int'(square), 0);
        chk("rst_pending", int'(div_pending), 0);

        // Free-running ticks at the default divisor
        reset = 1'b0; enable = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            @(posedge clock);
            #1;
            chk($sformatf("t1_tick_e%0d", i), int'(tick), (i % 5 == 0) ? 1 : 0);
            chk($sformatf("t1_wrap_e%0d", i), int'(wrap_pulse), (i == 15) ? 1 : 0);
            if (i == 5)  begin chk("t1_cnt5",  int'(tick_count), 1); chk("t1_sq5",  int'(square), 1); end
            if (i == 10) begin chk("t1_cnt10", int'(tick_count), 2); chk("t1_sq10", int'(square), 0); end
            if (i == 15) chk("t1_cnt15", int'(tick_count), 0);
        end
        @(negedge clock);

        // Freeze mid-period
        cyc(2);
        enable = 1'b0;
        cyc(4);
        chk("t2_hold_cnt", int'(tick_count), 0);
        chk("t2_hold_tick", int'(tick), 0);
        enable = 1'b1;
        wait_tick(n);
        chk("t2_delay", n, 3);
        chk("t2_cnt", int'(tick_count), 1);

        // Rejected divisors
        load(1);
        chk("t4_err1", int'(div_err), 1);
        chk("t4_pend1", int'(div_pending), 0);
        cyc(1);
        chk("t4_err1_off", int'(div_err), 0);
        wait_tick(n);
        chk("t4_period1", n, 3);
        load(0);
        chk("t4_err0", int'(div_err), 1);
        cyc(1);
        chk("t4_err0_off", int'(div_err), 0);
        wait_tick(n);
        chk("t4_period0", n, 3);

        // Clear with a pending divisor
        wait_tick(n);
        wait_tick(n);
        chk("t5_cnt_pre", int'(tick_count), 2);
        load(4);
        chk("t5_pend", int'(div_pending), 1);
        cyc(2);
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
        chk("t5_cnt", int'(tick_count), 0);
        chk("t5_sq", int'(square), 0);
        chk("t5_pend_off", int'(div_pending), 0);
        wait_tick(n);
        chk("t5_first", n, 4);
        chk("t5_wrap", int'(wrap_pulse), 0);
        chk("t5_cnt1", int'(tick_count), 1);
        wait_tick(n);
        chk("t5_period", n, 4);

        // Reset mid-period discards a pending load
        cyc(1);
        load(7);
        chk("t6_pend", int'(div_pending), 1);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        chk("t6_tick", int'(tick), 0);
        chk("t6_cnt", int'(tick_count), 0);
        chk("t6_wrap", int'(wrap_pulse), 0);
        chk("t6_sq", int'(square), 0);
        chk("t6_pend_off", int'(div_pending), 0);
        chk("t6_err", int'(div_err), 0);
        wait_tick(n);
        chk("t6_first", n, 5);
        wait_tick(n);
        chk("t6_period", n, 5);

        // Load mid-period: old period completes, then new one
        cyc(1);
        load(3);
        chk("t3_pend", int'(div_pending), 1);
        wait_tick(n);
        chk("t3_old", n, 3);
        chk("t3_pend_off", int'(div_pending), 0);
        wait_tick(n);
        chk("t3_new_a", n, 3);
        wait_tick(n);
        chk("t3_new_b", n, 3);

        // Load on the terminal edge, then back-to-back loads
        cyc(2);
        load(6);
        chk("t7_tick", int'(tick), 1);
        chk("t7_pend", int'(div_pending), 0);
        load(4);
        load(2);
        wait_tick(n);
        chk("t7_six", n, 4);
        wait_tick(n);
        chk("t7_latest", n, 2);

        // Load while frozen stays pending
        enable = 1'b0;
        load(5);
        cyc(3);
        chk("t8_pend", int'(div_pending), 1);
        enable = 1'b1;
        wait_tick(n);
        chk("t8_old", n, 2);
        wait_tick(n);
        chk("t8_new", n, 5);

        cyc(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
